// File: rtl/hazard_ctrl_mc.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_mc
//
// Pipeline hazard controller for the 5-stage RISC-V core.
//   - Inserts LOAD_STALL bubbles for a load-use dependency between the
//     instruction in decode and a load in execute.
//   - Holds IF/ID/EX while a multi-cycle execute op (e.g. the divider) runs,
//     until the unit pulses mc_done.
//   - A taken branch in execute flushes IF/ID and ID/EX and wins over any
//     stall request raised in the same cycle.
//   - Counts cycles with stallF=1 in a saturating performance counter.
//
// Parameters:
//   REG_AW     register address width
//   LOAD_STALL bubbles per load-use hazard (1..7)
//   CNT_W      bubble counter width, must hold LOAD_STALL
//   PERF_W     stall-cycle counter width
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   rs1_addr_D/rs2_addr_D      source registers of the decode instruction
//   rs1_used_D/rs2_used_D      decode instruction actually reads rs1/rs2
//   rd_E, regwrite_E, sel_wb_E destination / write enable / wb select in EX
//   mc_start_E, mc_done        multi-cycle op present in EX / result ready
//   branch_taken_E             branch or jump resolved taken in EX
//   stallF, stallD, stallE     hold PC, IF/ID, ID/EX
//   flushD, flushE             clear IF/ID, ID/EX
//   stall_cycles               saturating count of cycles with stallF=1
// -----------------------------------------------------------------------------
module hazard_ctrl_mc #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr_D,
  input  logic [REG_AW-1:0] rs2_addr_D,
  input  logic              rs1_used_D,
  input  logic              rs2_used_D,
  input  logic [REG_AW-1:0] rd_E,
  input  logic              regwrite_E,
  input  logic [1:0]        sel_wb_E,
  input  logic              mc_start_E,
  input  logic              mc_done,
  input  logic              branch_taken_E,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LD_WAIT = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

  localparam logic [1:0]       SEL_WB_LOAD = 2'b00;
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX   = {PERF_W{1'b1}};

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [PERF_W-1:0] perf_reg;

  // Raw controls from the output decoder, before reset gating.
  logic stallf_raw, stalld_raw, stalle_raw, flushd_raw, flushe_raw;

  // ---------------------------------------------------------------------------
  // Load-use detection: one match lane per decode source operand.
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] src_addr [2];
  logic [1:0]        src_used;
  logic [1:0]        src_match;
  logic              ex_is_load;
  logic              load_use;

  assign src_addr[0] = rs1_addr_D;
  assign src_addr[1] = rs2_addr_D;
  assign src_used    = {rs2_used_D, rs1_used_D};

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign ex_is_load = (sel_wb_E == SEL_WB_LOAD) & regwrite_E & (rd_E != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = src_used[gi] & (src_addr[gi] == rd_E);
    end
  endgenerate

  assign load_use = ex_is_load & (|src_match);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      RUN: begin
        if (branch_taken_E) begin
          // The flush kills the dependent instruction; nothing to wait for.
          state_next = RUN;
        end else if (mc_start_E) begin
          // A unit that finishes in the issue cycle needs no wait state.
          if (!mc_done) begin
            state_next = MC_WAIT;
          end
        end else if (load_use) begin
          // This cycle is the first bubble; LD_WAIT covers the remainder.
          if (LOAD_STALL > 1) begin
            state_next = LD_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      LD_WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg <= CNT_ONE) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    stallf_raw = 1'b0;
    stalld_raw = 1'b0;
    stalle_raw = 1'b0;
    flushd_raw = 1'b0;
    flushe_raw = 1'b0;
    unique case (state_reg)
      RUN: begin
        if (branch_taken_E) begin
          flushd_raw = 1'b1;
          flushe_raw = 1'b1;
        end else if (mc_start_E) begin
          if (!mc_done) begin
            stallf_raw = 1'b1;
            stalld_raw = 1'b1;
            stalle_raw = 1'b1;
          end
        end else if (load_use) begin
          // Hold F/D and push a bubble into EX.
          stallf_raw = 1'b1;
          stalld_raw = 1'b1;
          flushe_raw = 1'b1;
        end
      end
      LD_WAIT: begin
        // EX holds a bubble, so a taken branch cannot appear here.
        stallf_raw = 1'b1;
        stalld_raw = 1'b1;
        flushe_raw = 1'b1;
      end
      MC_WAIT: begin
        // In the done cycle the result moves on and the pipe resumes.
        if (!mc_done) begin
          stallf_raw = 1'b1;
          stalld_raw = 1'b1;
          stalle_raw = 1'b1;
        end
      end
      default: begin
        stallf_raw = 1'b0;
      end
    endcase
  end

  // Gating with rst_n makes the controls drop the moment reset asserts,
  // without waiting for the state register to settle on a clock edge.
  assign stallF = stallf_raw & rst_n;
  assign stallD = stalld_raw & rst_n;
  assign stallE = stalle_raw & rst_n;
  assign flushD = flushd_raw & rst_n;
  assign flushE = flushe_raw & rst_n;

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reg <= '0;
    end else if (stallF && (perf_reg != PERF_MAX)) begin
      perf_reg <= perf_reg + PERF_W'(1);
    end
  end

  assign stall_cycles = perf_reg;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_mc
//
// Directed bench for hazard_ctrl_mc. Two instances share one stimulus bus:
//   u1: LOAD_STALL=1, PERF_W=4  (single bubble, small counter for saturation)
//   u3: LOAD_STALL=3, PERF_W=16 (three bubbles)
// Output vectors are packed as {stallF, stallD, stallE, flushD, flushE}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_mc;

  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] LDS  = 5'b11001;  // stallF, stallD, flushE
  localparam logic [4:0] MCS  = 5'b11100;  // stallF, stallD, stallE
  localparam logic [4:0] BRF  = 5'b00011;  // flushD, flushE

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_addr_D, rs2_addr_D, rd_E;
  logic       rs1_used_D, rs2_used_D, regwrite_E;
  logic [1:0] sel_wb_E;
  logic       mc_start_E, mc_done, branch_taken_E;

  logic        sf1, sd1, se1, fd1, fe1;
  logic        sf3, sd3, se3, fd3, fe3;
  logic [3:0]  sc1;
  logic [15:0] sc3;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(3), .PERF_W(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
    .rd_E(rd_E), .regwrite_E(regwrite_E), .sel_wb_E(sel_wb_E),
    .mc_start_E(mc_start_E), .mc_done(mc_done), .branch_taken_E(branch_taken_E),
    .stallF(sf1), .stallD(sd1), .stallE(se1), .flushD(fd1), .flushE(fe1),
    .stall_cycles(sc1)
  );

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(3), .PERF_W(16)) u3 (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
    .rd_E(rd_E), .regwrite_E(regwrite_E), .sel_wb_E(sel_wb_E),
    .mc_start_E(mc_start_E), .mc_done(mc_done), .branch_taken_E(branch_taken_E),
    .stallF(sf3), .stallD(sd3), .stallE(se3), .flushD(fd3), .flushE(fe3),
    .stall_cycles(sc3)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e1, input logic [4:0] e3);
    chk({tag, "_u1"}, {11'd0, sf1, sd1, se1, fd1, fe1}, {11'd0, e1});
    chk({tag, "_u3"}, {11'd0, sf3, sd3, se3, fd3, fe3}, {11'd0, e3});
    $display("step %s: u1=%b u3=%b sc1=%0d sc3=%0d", tag,
             {sf1, sd1, se1, fd1, fe1}, {sf3, sd3, se3, fd3, fe3}, sc1, sc3);
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] e1, input logic [15:0] e3);
    chk({tag, "_sc1"}, {12'd0, sc1}, e1);
    chk({tag, "_sc3"}, sc3, e3);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs are already applied; let them settle, check, then clock once.
  task automatic step(input string tag, input logic [4:0] e1, input logic [4:0] e3);
    #1;
    chk_out(tag, e1, e3);
    cyc();
  endtask

  task automatic set_idle();
    rs1_addr_D = 5'd0; rs2_addr_D = 5'd0;
    rs1_used_D = 1'b0; rs2_used_D = 1'b0;
    rd_E = 5'd0; regwrite_E = 1'b0; sel_wb_E = 2'b01;
    mc_start_E = 1'b0; mc_done = 1'b0; branch_taken_E = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1_, input logic u2_);
    set_idle();
    rd_E = rd; rs1_addr_D = r1; rs2_addr_D = r2;
    rs1_used_D = u1_; rs2_used_D = u2_;
    regwrite_E = 1'b1; sel_wb_E = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    #2;
    chk_out("reset", IDLE, IDLE);
    chk_cnt("reset", 16'd0, 16'd0);
    #1 rst_n = 1'b1;

    step("idle", IDLE, IDLE);

    // Load-use on rs1: one bubble for u1, three for u3.
    set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    step("ld_rs1_c0", LDS, LDS);
    set_idle();
    step("ld_rs1_c1", IDLE, LDS);
    step("ld_rs1_c2", IDLE, LDS);
    step("ld_rs1_c3", IDLE, IDLE);
    chk_cnt("ld_rs1", 16'd1, 16'd3);

    // Load-use on rs2.
    set_load(5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    step("ld_rs2_c0", LDS, LDS);
    set_idle();
    step("ld_rs2_c1", IDLE, LDS);
    step("ld_rs2_c2", IDLE, LDS);
    step("ld_rs2_c3", IDLE, IDLE);
    chk_cnt("ld_rs2", 16'd2, 16'd6);

    // Filter cases: none of these is a hazard.
    set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    step("flt_rd0", IDLE, IDLE);
    set_load(5'd9, 5'd1, 5'd9, 1'b1, 1'b0);
    step("flt_rs2_unused", IDLE, IDLE);
    set_load(5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
    regwrite_E = 1'b0;
    step("flt_no_regwrite", IDLE, IDLE);
    set_load(5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
    sel_wb_E = 2'b01;
    step("flt_not_load", IDLE, IDLE);
    chk_cnt("flt", 16'd2, 16'd6);

    // Taken branch beats a simultaneous load-use; FSM stays in RUN.
    set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    branch_taken_E = 1'b1;
    step("br_ld", BRF, BRF);
    set_idle();
    step("br_after", IDLE, IDLE);
    chk_cnt("br", 16'd2, 16'd6);

    // Multi-cycle op: done arrives 4 cycles after start.
    mc_start_E = 1'b1;
    step("mc_c0", MCS, MCS);
    mc_start_E = 1'b0;
    step("mc_c1", MCS, MCS);
    step("mc_c2", MCS, MCS);
    step("mc_c3", MCS, MCS);
    mc_done = 1'b1;
    step("mc_done", IDLE, IDLE);
    mc_done = 1'b0;
    step("mc_after", IDLE, IDLE);
    chk_cnt("mc", 16'd6, 16'd10);

    // Zero-latency op: start and done together cause no stall.
    mc_start_E = 1'b1;
    mc_done    = 1'b1;
    step("mc_zero", IDLE, IDLE);
    set_idle();
    step("mc_zero_after", IDLE, IDLE);
    chk_cnt("mc_zero", 16'd6, 16'd10);

    // Reset dropped while in MC_WAIT, away from any clock edge.
    mc_start_E = 1'b1;
    step("mcr_c0", MCS, MCS);
    mc_start_E = 1'b0;
    #1;
    chk_out("mcr_wait", MCS, MCS);
    #1 rst_n = 1'b0;
    #1;
    chk_out("mcr_async", IDLE, IDLE);
    chk_cnt("mcr_async", 16'd0, 16'd0);
    #1 rst_n = 1'b1;
    step("post_rst_c0", IDLE, IDLE);
    step("post_rst_c1", IDLE, IDLE);
    chk_cnt("post_rst", 16'd0, 16'd0);

    // Continuous hazard: every cycle stalls; u1's 4-bit counter saturates.
    set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    repeat (14) cyc();
    chk_cnt("sat14", 16'd14, 16'd14);
    repeat (6) cyc();
    chk_cnt("sat20", 16'd15, 16'd20);
    set_idle();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
